mdu_iter: RTL and testbench
===========================

# mdu_iter

Parametrised iterative multiply/divide unit with architectural HI/LO registers for the MIPS execute stage. It services the core's `md_start_E` / `md_run_E` / `hilosrcE` path. It generalises the fixed 32-bit, one-bit-per-cycle unit: operand width and bits retired per cycle are configurable. It adds MADD/MSUB accumulate, defined divide-by-zero behaviour and an exception-driven abort.

## Interface
- `WIDTH`, default 32: operand, HI and LO width. Must be even and ≥ 8.
- `UNROLL`, default 1: bits retired per iteration cycle. Must divide `WIDTH`. N = WIDTH/UNROLL.
- `clk` in 1: single clock, all state updates on the rising edge.
- `reset` in 1: reset is synchronous and active-high.
- `start` in 1: launch the operation in `op`. Sampled only when `busy`=0.
- `op` in 3: operation code.
  - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU.
  - 100 MADD, 101 MADDU, 110 MSUB, 111 MSUBU.
- `a` in WIDTH: rs operand, latched at start.
- `b` in WIDTH: rt operand, latched at start.
- `hi_we` in 1: MTHI write strobe.
- `lo_we` in 1: MTLO write strobe.
- `wdata` in WIDTH: data for `hi_we` / `lo_we`.
- `flush` in 1: abort the in-flight operation (exception / branch-delay-slot kill).
- `busy` out 1: operation in flight. Drives the core's `md_run_E` stall.
- `hi` out WIDTH: HI register.
- `lo` out WIDTH: LO register.

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE, `busy`=0, `hi`=0, `lo`=0, internal counter=0.
- IDLE → RUN on `start` & !`flush`:
  - latch `a`, `b`, `op`;
  - for signed ops, latch magnitudes and the sign flags;
  - load counter with N.
- RUN, one iteration per cycle:
  - Multiply: radix-2^UNROLL shift-add on magnitudes.
  - Divide: restoring divide on magnitudes, UNROLL quotient bits per cycle.
  - Counter decrements each cycle. Counter reaching 0 → DONE.
- DONE, one cycle:
  - apply sign fix-up;
  - for accumulate ops, read `{hi,lo}` as they are in this cycle;
  - write results to HI/LO; → IDLE.
- Multiply results:
  - `{hi,lo}` = full 2·WIDTH-bit product.
  - MADD*: `{hi,lo}` + product. MSUB*: `{hi,lo}` − product. Both mod 2^(2·WIDTH).
  - Signed variants treat the product as signed.
- Divide results:
  - `lo` = quotient truncated toward zero.
  - `hi` = remainder, carrying the sign of the dividend.
- Divide by zero (any DIV/DIVU): `lo` = all ones, `hi` = `a`. Latency is unchanged.
- Signed most-negative ÷ −1: `lo` = most-negative (wrap), `hi` = 0.
- `hi_we` / `lo_we` with `busy`=0: the write lands at the edge. Both may be asserted together.
- `hi_we` / `lo_we` with `busy`=1: ignored. The controller stalls MTHI/MTLO on `busy`.
- `start` while `busy`=1: ignored. No queueing.
- `flush` in RUN or DONE: → IDLE at the edge, HI/LO unchanged, `busy`=0 next cycle.
- `flush` and `start` in the same cycle: flush wins and the start is dropped.
- `start` with `hi_we` / `lo_we` in the same IDLE cycle: the write lands. A subsequent MADD/MSUB accumulates onto the written value.
- `reset` has priority over everything. Asserting it mid-operation returns to the reset state at that edge.

## Timing
- Start accepted at edge E0. `busy`=1 from the cycle after E0 for N+1 cycles (N RUN + 1 DONE).
- HI/LO take the new value at edge E0+N+1. That value and `busy`=0 are visible in the same cycle.
- WIDTH=32, UNROLL=1: 33 busy cycles. UNROLL=4: 9 busy cycles.
- Back-to-back: a new `start` may be asserted in the first cycle `busy` reads 0.
- Outputs `hi`, `lo` and `busy` are registered. There is no combinational path from inputs to outputs.

## Test plan
- MULT, `a`=0xFFFFFFFD (−3), `b`=5:
  - `busy` high exactly 33 cycles;
  - then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1.
- DIVU 100/7 → `lo`=14, `hi`=2.
- DIV −7/2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- DIV 0x80000000/0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- DIVU 0x1234/0 → `lo`=0xFFFFFFFF, `hi`=0x1234.
- Accumulate onto `hi`=0, `lo`=0xFFFFFFFF (loaded via MTHI/MTLO):
  - MADDU 1×1 → `hi`=1, `lo`=0;
  - then MSUB 2×3 → `hi`=0, `lo`=0xFFFFFFFA.
- MULT 7×9 with `flush` at busy cycle 10:
  - `busy`=0 next cycle;
  - HI/LO keep their prior values;
  - a `start` pulsed at busy cycle 5 is ignored;
  - `hi_we` at busy cycle 6 is ignored.
- WIDTH=16, UNROLL=4, MULTU 0xFFFF×0xFFFF:
  - `busy` 5 cycles;
  - `hi`=0xFFFE, `lo`=0x0001.
- WIDTH=16, UNROLL=4, `reset` at busy cycle 2: `busy`=0, `hi`=`lo`=0 at the next cycle.

Source files
------------

// File: rtl/mdu_iter_if.sv
// Core-side bundle for the iterative multiply/divide unit: launch controls,
// MTHI/MTLO writes, abort, and the architectural HI/LO read-back.
interface mdu_iter_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             flush;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, hi_we, lo_we, wdata, flush,
        input  busy, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wdata, flush,
        output busy, hi, lo
    );
endinterface

// File: rtl/mdu_iter.sv
// Iterative MULT/DIV/MADD/MSUB unit with HI/LO registers; UNROLL bits retired
// per cycle on operand magnitudes, sign fix-up and accumulate in a final cycle.
module mdu_iter #(
    parameter int WIDTH  = 32,
    parameter int UNROLL = 1
) (
    input logic       clk,
    input logic       reset,
    mdu_iter_if.slave bus
);
    localparam int N  = WIDTH / UNROLL;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   a_q, mb;
    logic               neg_a, neg_b, b_zero;
    logic [2*WIDTH-1:0] work;
    logic [WIDTH-1:0]   hi_r, lo_r;
    logic [WIDTH-1:0]   hi_res, lo_res;
    logic               start_ok, is_div, sgn_in;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
        return (sgn && x[WIDTH-1]) ? -x : x;
    endfunction

    // work = {partial product, unconsumed multiplier bits}
    function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] p,
                                                    input logic [WIDTH-1:0] d);
        logic [UNROLL-1:0]       dg;
        logic [WIDTH+UNROLL-1:0] up;
        dg = p[UNROLL-1:0];
        up = {{UNROLL{1'b0}}, p[2*WIDTH-1:WIDTH]} +
             ({{UNROLL{1'b0}}, d} * {{WIDTH{1'b0}}, dg});
        return {up, p[WIDTH-1:UNROLL]};
    endfunction

    // work = {partial remainder, dividend bits shifting out / quotient bits shifting in}
    function automatic logic [2*WIDTH-1:0] div_step(input logic [2*WIDTH-1:0] p,
                                                    input logic [WIDTH-1:0] d);
        logic [WIDTH:0]   r;
        logic [WIDTH-1:0] q;
        r = {1'b0, p[2*WIDTH-1:WIDTH]};
        q = p[WIDTH-1:0];
        for (int i = 0; i < UNROLL; i++) begin
            r = {r[WIDTH-1:0], q[WIDTH-1]};
            q = {q[WIDTH-2:0], 1'b0};
            if (r >= {1'b0, d}) begin
                r    = r - {1'b0, d};
                q[0] = 1'b1;
            end
        end
        return {r[WIDTH-1:0], q};
    endfunction

    assign start_ok = bus.start && !bus.flush;
    assign sgn_in   = !bus.op[0];
    assign is_div   = !op_q[2] && op_q[1];

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start_ok) state_nxt = RUN;
            RUN: begin
                if (bus.flush)            state_nxt = IDLE;
                else if (cnt == CW'(1))   state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Final cycle: sign fix-up, then accumulate onto the current HI/LO
    always_comb begin
        logic [2*WIDTH-1:0] prod_s, mul_res;
        logic [WIDTH-1:0]   q, r;
        prod_s  = (neg_a ^ neg_b) ? -work : work;
        mul_res = prod_s;
        if (op_q[2]) mul_res = op_q[1] ? ({hi_r, lo_r} - prod_s) : ({hi_r, lo_r} + prod_s);
        q      = work[WIDTH-1:0];
        r      = work[2*WIDTH-1:WIDTH];
        hi_res = mul_res[2*WIDTH-1:WIDTH];
        lo_res = mul_res[WIDTH-1:0];
        if (is_div) begin
            if (b_zero) begin
                hi_res = a_q;
                lo_res = '1;
            end else begin
                hi_res = neg_a ? -r : r;
                lo_res = (neg_a ^ neg_b) ? -q : q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            hi_r <= '0;
            lo_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.hi_we) hi_r <= bus.wdata;
                    if (bus.lo_we) lo_r <= bus.wdata;
                    if (start_ok)  cnt  <= CW'(N);
                end
                RUN: cnt <= bus.flush ? '0 : cnt - CW'(1);
                DONE: begin
                    if (!bus.flush) begin
                        hi_r <= hi_res;
                        lo_r <= lo_res;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

    // Operand/working datapath carries no reset; it is always loaded at launch
    always_ff @(posedge clk) begin
        if (state == IDLE && start_ok) begin
            op_q   <= bus.op;
            a_q    <= bus.a;
            neg_a  <= sgn_in && bus.a[WIDTH-1];
            neg_b  <= sgn_in && bus.b[WIDTH-1];
            b_zero <= (bus.b == '0);
            mb     <= mag(bus.b, sgn_in);
            work   <= {{WIDTH{1'b0}}, mag(bus.a, sgn_in)};
        end else if (state == RUN) begin
            work <= is_div ? div_step(work, mb) : mul_step(work, mb);
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;
endmodule

// File: tb/tb_mdu_iter.sv
// Bench for mdu_iter: a 32-bit/1-bit-per-cycle and a 16-bit/4-bit-per-cycle instance,
// each checked every cycle against an arithmetic model, plus literal directed cases.
module tb_mdu_iter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        s_start[2], s_hi_we[2], s_lo_we[2], s_flush[2];
    logic [2:0]  s_op[2];
    logic [31:0] s_a[2], s_b[2], s_wd[2];

    mdu_iter_if #(.WIDTH(32)) bus32 ();
    mdu_iter_if #(.WIDTH(16)) bus16 ();

    assign bus32.start = s_start[0];
    assign bus32.op    = s_op[0];
    assign bus32.a     = s_a[0];
    assign bus32.b     = s_b[0];
    assign bus32.hi_we = s_hi_we[0];
    assign bus32.lo_we = s_lo_we[0];
    assign bus32.wdata = s_wd[0];
    assign bus32.flush = s_flush[0];

    assign bus16.start = s_start[1];
    assign bus16.op    = s_op[1];
    assign bus16.a     = s_a[1][15:0];
    assign bus16.b     = s_b[1][15:0];
    assign bus16.hi_we = s_hi_we[1];
    assign bus16.lo_we = s_lo_we[1];
    assign bus16.wdata = s_wd[1][15:0];
    assign bus16.flush = s_flush[1];

    mdu_iter #(.WIDTH(32), .UNROLL(1)) dut32 (.clk(clk), .reset(rst), .bus(bus32));
    mdu_iter #(.WIDTH(16), .UNROLL(4)) dut16 (.clk(clk), .reset(rst), .bus(bus16));

    function automatic logic dut_busy(int k);
        return (k == 0) ? bus32.busy : bus16.busy;
    endfunction
    function automatic logic [31:0] dut_hi(int k);
        return (k == 0) ? bus32.hi : {16'h0, bus16.hi};
    endfunction
    function automatic logic [31:0] dut_lo(int k);
        return (k == 0) ? bus32.lo : {16'h0, bus16.lo};
    endfunction

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Architectural result of one operation at width w; returns {hi, lo}
    function automatic logic [63:0] mdu_ref(int w, logic [2:0] op, logic [31:0] a, logic [31:0] b,
                                           logic [31:0] hi, logic [31:0] lo);
        longint mask, ua, ub, sa, sb, p, acc, r, q, rm;
        mask = (longint'(1) << w) - 1;
        ua   = longint'(a) & mask;
        ub   = longint'(b) & mask;
        sa   = (ua >= (longint'(1) << (w - 1))) ? ua - (longint'(1) << w) : ua;
        sb   = (ub >= (longint'(1) << (w - 1))) ? ub - (longint'(1) << w) : ub;
        if (op[2] || !op[1]) begin
            p   = op[0] ? ua * ub : sa * sb;
            acc = ((longint'(hi) & mask) << w) | (longint'(lo) & mask);
            r   = !op[2] ? p : (op[1] ? acc - p : acc + p);
            return {32'((r >> w) & mask), 32'(r & mask)};
        end
        if (ub == 0) return {32'(ua), 32'(mask)};
        q  = op[0] ? ua / ub : sa / sb;
        rm = op[0] ? ua % ub : sa % sb;
        return {32'(rm & mask), 32'(q & mask)};
    endfunction

    logic [31:0] m_hi[2], m_lo[2], m_a[2], m_b[2];
    logic [2:0]  m_op[2];
    int          m_left[2];
    int          nedge = 0;

    // Predict the state after the next rising edge from the inputs it will sample
    task automatic model_step(int k);
        int          n, w;
        logic [31:0] msk, wd;
        logic [63:0] r;
        n   = (k == 0) ? 32 : 4;
        w   = (k == 0) ? 32 : 16;
        msk = (k == 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        wd  = s_wd[k] & msk;
        if (rst) begin
            m_hi[k] = '0; m_lo[k] = '0; m_left[k] = 0;
        end else if (m_left[k] > 0) begin
            if (s_flush[k]) m_left[k] = 0;
            else if (m_left[k] == 1) begin
                r = mdu_ref(w, m_op[k], m_a[k], m_b[k], m_hi[k], m_lo[k]);
                m_hi[k] = r[63:32]; m_lo[k] = r[31:0]; m_left[k] = 0;
            end else m_left[k] = m_left[k] - 1;
        end else begin
            if (s_hi_we[k]) m_hi[k] = wd;
            if (s_lo_we[k]) m_lo[k] = wd;
            if (s_start[k] && !s_flush[k]) begin
                m_op[k] = s_op[k]; m_a[k] = s_a[k] & msk; m_b[k] = s_b[k] & msk;
                m_left[k] = n + 1;
            end
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (nedge > 0) begin
                chk(k == 0 ? "cyc_busy32" : "cyc_busy16", {31'b0, dut_busy(k)}, {31'b0, (m_left[k] > 0)});
                chk(k == 0 ? "cyc_hi32" : "cyc_hi16", dut_hi(k), m_hi[k]);
                chk(k == 0 ? "cyc_lo32" : "cyc_lo16", dut_lo(k), m_lo[k]);
            end
            model_step(k);
        end
        nedge++;
    end

    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(int k, logic [2:0] op, logic [31:0] a, logic [31:0] b);
        s_start[k] = 1'b1; s_op[k] = op; s_a[k] = a; s_b[k] = b;
        cyc(1);
        s_start[k] = 1'b0;
    endtask

    task automatic wait_idle(int k, output int nb);
        nb = 0;
        while (dut_busy(k) && nb < 200) begin
            nb++;
            cyc(1);
        end
        if (nb >= 200) begin
            checks++; errors++;
            $display("FAIL wait_idle%0d: busy still 1 after %0d cycles, expected 0", k, nb);
        end
    endtask

    task automatic run_chk(int k, string name, logic [2:0] op, logic [31:0] a, logic [31:0] b,
                           logic [31:0] exp_hi, logic [31:0] exp_lo, int exp_busy);
        int nb;
        issue(k, op, a, b);
        wait_idle(k, nb);
        chk({name, "_busy"}, nb, exp_busy);
        chk({name, "_hi"}, dut_hi(k), exp_hi);
        chk({name, "_lo"}, dut_lo(k), exp_lo);
    endtask

    task automatic rand_op(int k);
        logic [2:0]  op;
        logic [31:0] a, b;
        int          nb;
        op = 3'($urandom_range(0, 7));
        a  = $urandom;
        b  = $urandom;
        case ($urandom_range(0, 9))
            0: b = '0;
            1: begin a = (k == 0) ? 32'h8000_0000 : 32'h0000_8000; b = 32'hFFFF_FFFF; end
            2: b = 32'($urandom_range(1, 3));
            default: ;
        endcase
        if ($urandom_range(0, 3) == 0) begin
            s_hi_we[k] = 1'b1; s_wd[k] = $urandom;
            cyc(1);
            s_hi_we[k] = 1'b0;
        end
        if ($urandom_range(0, 3) == 0) begin
            s_lo_we[k] = 1'b1; s_wd[k] = $urandom;
        end
        s_flush[k] = ($urandom_range(0, 15) == 0);
        issue(k, op, a, b);
        s_lo_we[k] = 1'b0; s_flush[k] = 1'b0;
        nb = 0;
        while (dut_busy(k) && nb < 100) begin
            s_start[k] = ($urandom_range(0, 7) == 0);
            s_op[k]    = 3'($urandom_range(0, 7));
            s_a[k]     = $urandom;
            s_hi_we[k] = ($urandom_range(0, 7) == 0);
            s_lo_we[k] = ($urandom_range(0, 7) == 0);
            s_wd[k]    = $urandom;
            s_flush[k] = ($urandom_range(0, 49) == 0);
            cyc(1);
            s_start[k] = 1'b0; s_hi_we[k] = 1'b0; s_lo_we[k] = 1'b0; s_flush[k] = 1'b0;
            nb++;
        end
        if (nb >= 100) begin
            checks++; errors++;
            $display("FAIL rand_wait%0d: busy still 1 after %0d cycles, expected 0", k, nb);
        end
        cyc($urandom_range(0, 2));
    endtask

    initial begin
        int nb;
        for (int k = 0; k < 2; k++) begin
            s_start[k] = 1'b0; s_hi_we[k] = 1'b0; s_lo_we[k] = 1'b0; s_flush[k] = 1'b0;
            s_op[k] = '0; s_a[k] = '0; s_b[k] = '0; s_wd[k] = '0;
        end
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        chk("reset_busy32", {31'b0, dut_busy(0)}, 32'd0);
        chk("reset_hi32", dut_hi(0), 32'd0);
        chk("reset_lo32", dut_lo(0), 32'd0);
        chk("reset_busy16", {31'b0, dut_busy(1)}, 32'd0);

        run_chk(0, "mult_m3x5", 3'b000, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 33);
        run_chk(0, "divu_100_7", 3'b011, 32'd100, 32'd7, 32'd2, 32'd14, 33);
        run_chk(0, "div_m7_2", 3'b010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
        run_chk(0, "div_ovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 33);
        run_chk(0, "divu_zero", 3'b011, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, 33);

        // MTHI 0, then MTLO all-ones in the same cycle as the MADDU launch
        s_hi_we[0] = 1'b1; s_wd[0] = 32'd0;
        cyc(1);
        s_hi_we[0] = 1'b0;
        s_lo_we[0] = 1'b1; s_wd[0] = 32'hFFFF_FFFF;
        issue(0, 3'b101, 32'd1, 32'd1);
        s_lo_we[0] = 1'b0;
        wait_idle(0, nb);
        chk("maddu_busy", nb, 33);
        chk("maddu_hi", dut_hi(0), 32'd1);
        chk("maddu_lo", dut_lo(0), 32'd0);
        run_chk(0, "msub_2x3", 3'b110, 32'd2, 32'd3, 32'd0, 32'hFFFF_FFFA, 33);

        issue(0, 3'b000, 32'd7, 32'd9);
        for (int c = 1; c <= 10; c++) begin
            if (c == 5) begin s_start[0] = 1'b1; s_op[0] = 3'b011; s_a[0] = 32'd1; s_b[0] = 32'd1; end
            if (c == 6) begin s_hi_we[0] = 1'b1; s_wd[0] = 32'h0000_DEAD; end
            if (c == 10) s_flush[0] = 1'b1;
            cyc(1);
            s_start[0] = 1'b0; s_hi_we[0] = 1'b0; s_flush[0] = 1'b0;
        end
        chk("flush_busy", {31'b0, dut_busy(0)}, 32'd0);
        chk("flush_hi", dut_hi(0), 32'd0);
        chk("flush_lo", dut_lo(0), 32'hFFFF_FFFA);

        s_flush[0] = 1'b1;
        issue(0, 3'b000, 32'd3, 32'd3);
        s_flush[0] = 1'b0;
        chk("flush_start_busy", {31'b0, dut_busy(0)}, 32'd0);
        cyc(1);
        chk("flush_start_lo", dut_lo(0), 32'hFFFF_FFFA);

        run_chk(1, "multu16", 3'b001, 32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_FFFE, 32'h0000_0001, 5);

        issue(1, 3'b000, 32'd3, 32'd5);
        cyc(1);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("rst16_busy", {31'b0, dut_busy(1)}, 32'd0);
        chk("rst16_hi", dut_hi(1), 32'd0);
        chk("rst16_lo", dut_lo(1), 32'd0);
        chk("rst32_lo", dut_lo(0), 32'd0);

        for (int i = 0; i < 400; i++) rand_op(i % 2);

        cyc(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
